stage_3_low_update: RTL and testbench
=====================================

Name: stage_3_low_update

Overview:
- Downstream neighbour of the Q15/bool encode-and-normalize stage.
- Consumes that stage's per-symbol results (u, v_bool, initial range, shift d, bool/symbol flags, COMP_mux_1).
- Maintains the AV1 arithmetic-coder low register and bit counter, and emits pre-carry bytes (8 data bits plus carry in bit 8).
- Runs the end-of-stream flush sequence.

Parameters:
- RANGE_WIDTH, 16, range/u/v width (u, v_bool are RANGE_WIDTH+1).
- D_SIZE, 5, width of normalization shift d.
- LOW_WIDTH, 24, low register width; the adder is LOW_WIDTH+1 so the carry is kept.
- CNT_WIDTH, 7, signed bit-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  stage-2 outputs valid this cycle
- in_ready  out  1  block accepts symbols (low during flush)
- u  in  RANGE_WIDTH+1  u from stage 2
- v_bool  in  RANGE_WIDTH+1  v_bool from stage 2
- initial_range  in  RANGE_WIDTH  pre-update range
- in_d  in  D_SIZE  normalization shift
- bool_symbol  in  2  [1] bool flag, [0] symbol bit
- COMP_mux_1  in  1  1 = symbol below top of CDF (low is updated)
- flush  in  1  request end-of-stream flush (level, sampled when idle)
- out_flag  out  2  number of valid bytes this cycle (0, 1, 2)
- out_bit_1  out  9  first pre-carry byte
- out_bit_2  out  9  second pre-carry byte
- end_of_stream  out  1  one-cycle pulse when flush completes

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low on port reset.
- Reset values:
  - low = 0, cnt = -9, state = S_RUN.
  - out_flag = 0, out_bit_1 = 0, out_bit_2 = 0, end_of_stream = 0, in_ready = 1.
- Symbol accept: in_valid && in_ready. All outputs are registered, so latency is 1 cycle. One symbol per cycle, no bubbles.
- Addend:
  - bool_symbol[1]=1: add = bool_symbol[0] ? initial_range - v_bool[RANGE_WIDTH-1:0] : 0.
  - bool_symbol[1]=0: add = COMP_mux_1 ? initial_range - u[RANGE_WIDTH-1:0] : 0.
- Update:
  - sum = low + add, computed at LOW_WIDTH+1 bits.
  - s = cnt + in_d, signed.
  - s < 0: no emission; low = sum << in_d (truncated to LOW_WIDTH); cnt = s.
  - s >= 0: c = cnt + 16.
    - If s >= 8: out_bit_1 = sum >> c; sum &= (1<<c)-1; c -= 8; out_bit_2 = sum >> c; out_flag = 2.
    - Else: out_bit_1 = sum >> c; out_flag = 1.
    - Then sum &= (1<<c)-1; cnt = c + in_d - 24; low = sum << in_d.
  - out_flag returns to 0 on any cycle without emission. Unused out_bit lanes hold 0.
- FSM:
  - S_RUN: accepts symbols. flush=1 with in_valid=0 moves to S_FLUSH.
    - Compute e = ((low + 0x3FFF) & ~0x3FFF) | 0x4000, c = cnt, s = cnt + 10.
    - If in_valid and flush are both high, the symbol is processed first and flush is taken next cycle.
  - S_FLUSH: in_ready = 0.
    - While s > 0, each cycle: out_bit_1 = e >> (c+16); out_flag = 1; e &= (1<<(c+16))-1; c -= 8; s -= 8.
    - When s <= 0, go to S_DONE without emitting.
  - S_DONE: end_of_stream = 1 for one cycle; low = 0; cnt = -9; return to S_RUN with in_ready = 1.
- Reset asserted mid-flush: immediate return to reset values; no end_of_stream.
- Inputs are ignored while in_ready = 0. Upstream must hold off.

Optional Feature:
- Macro: STAGE_3_SYMBOL_COUNTER_EN.
- Defined: adds output symbol_count [31:0].
  - Increments on every accepted symbol; wraps at 2^32.
  - Cleared by reset and in S_DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then idle -> out_flag=0, out_bits=0, in_ready=1; internal low=0, cnt=-9.
- Non-bool, COMP_mux_1=1, initial_range=0x8000, u=0x6000, d=1 from reset -> low=0x4000, cnt=-8, out_flag=0.
- Bool, bool_symbol=2'b11, initial_range=0x8000, v_bool=0x4004, d=1 from reset -> low=0x7FF8, cnt=-8, out_flag=0.
- cnt=-9, sum=0x00ABCD, d=9 -> next cycle out_flag=1, out_bit_1=0x157 (carry set); low=0x9A00, cnt=-8.
- cnt=-1, sum=0x123456, d=9 -> out_flag=2, out_bit_1=0x024, out_bit_2=0x068; low=0xAC00, cnt=-8.
- From reset, assert flush -> exactly one byte 0x080 (out_flag=1), then end_of_stream pulse; in_ready low throughout; afterwards low=0, cnt=-9.

Source files
------------

// File: rtl/stage_3_low_update.sv
// -----------------------------------------------------------------------------
// stage_3_low_update
//
// Third stage of the AV1 arithmetic encoder. Takes the per-symbol results of
// the encode-and-normalize stage, maintains the coder "low" register and the
// signed bit counter, and emits pre-carry bytes. Each byte is 9 bits wide:
// 8 data bits plus the pending carry in bit 8. Also runs the end-of-stream
// flush that drains the remaining bits of low.
//
// Ports
//   clk, reset     : clock, asynchronous active-low reset
//   in_valid       : upstream symbol valid
//   in_ready       : symbol accepted when high (low while flushing)
//   u, v_bool      : stage-2 u / v_bool (only the low RANGE_WIDTH bits are used)
//   initial_range  : range before this symbol's update
//   in_d           : normalization shift
//   bool_symbol    : [1] bool symbol flag, [0] bool bit value
//   COMP_mux_1     : 1 = symbol is below the top of the CDF, so low moves
//   flush          : end-of-stream request, sampled only when idle
//   out_flag       : number of valid bytes this cycle (0, 1 or 2)
//   out_bit_1/2    : first / second pre-carry byte (0 when unused)
//   end_of_stream  : one-cycle pulse when the flush completes
//   symbol_count   : accepted-symbol counter (only with the option below)
//
// Build option
//   STAGE_3_SYMBOL_COUNTER_EN : adds the 32-bit symbol_count output.
// -----------------------------------------------------------------------------
module stage_3_low_update #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int LOW_WIDTH   = 24,
  parameter int CNT_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH:0]   u,
  input  logic [RANGE_WIDTH:0]   v_bool,
  input  logic [RANGE_WIDTH-1:0] initial_range,
  input  logic [D_SIZE-1:0]      in_d,
  input  logic [1:0]             bool_symbol,
  input  logic                   COMP_mux_1,
  input  logic                   flush,
  output logic [1:0]             out_flag,
  output logic [8:0]             out_bit_1,
  output logic [8:0]             out_bit_2,
`ifdef STAGE_3_SYMBOL_COUNTER_EN
  output logic [31:0]            symbol_count,
`endif
  output logic                   end_of_stream
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FLUSH = 2'd1, S_DONE = 2'd2} state_t;
  typedef logic signed [CNT_WIDTH-1:0] cnt_t;

  // One extra bit on the adder keeps the carry out of low.
  localparam int SUM_WIDTH = LOW_WIDTH + 1;

  localparam cnt_t CNT_INIT = cnt_t'(-9);
  localparam cnt_t CNT_0    = cnt_t'(0);
  localparam cnt_t CNT_8    = cnt_t'(8);
  localparam cnt_t CNT_10   = cnt_t'(10);
  localparam cnt_t CNT_16   = cnt_t'(16);
  localparam cnt_t CNT_24   = cnt_t'(24);

  localparam logic [SUM_WIDTH-1:0] SUM_ONE    = SUM_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0] FLUSH_MASK = SUM_WIDTH'(15'h3FFF);
  localparam logic [SUM_WIDTH-1:0] FLUSH_BIT  = SUM_WIDTH'(15'h4000);

  state_t                 state_q, state_d;
  logic [LOW_WIDTH-1:0]   low_q, low_d;
  cnt_t                   cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]   e_q, e_d;      // flush copy of low
  cnt_t                   fc_q, fc_d;    // flush bit position
  cnt_t                   fs_q, fs_d;    // flush bits still to drain
  logic [1:0]             out_flag_q, out_flag_d;
  logic [8:0]             out_bit_1_q, out_bit_1_d;
  logic [8:0]             out_bit_2_q, out_bit_2_d;
  logic                   eos_q, eos_d;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
  logic [31:0]            count_q, count_d;
`endif

  // Symbol datapath
  logic [RANGE_WIDTH-1:0] add_r;
  logic [SUM_WIDTH-1:0]   sum, sum_m1, sum_m2, sum_fin, e_init, fmask;
  cnt_t                   d_s, s_sym, c_hi, c_lo, c_fin, fsh;
  logic                   two_bytes;

  // Bit RANGE_WIDTH of u / v_bool never reaches the addend.
  logic unused_msbs;
  assign unused_msbs = u[RANGE_WIDTH] ^ v_bool[RANGE_WIDTH];

  assign in_ready = (state_q == S_RUN);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    low_d       = low_q;
    cnt_d       = cnt_q;
    e_d         = e_q;
    fc_d        = fc_q;
    fs_d        = fs_q;
    out_flag_d  = 2'd0;
    out_bit_1_d = 9'd0;
    out_bit_2_d = 9'd0;
    eos_d       = 1'b0;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
    count_d     = count_q;
`endif

    if (bool_symbol[1]) add_r = bool_symbol[0] ? initial_range - v_bool[RANGE_WIDTH-1:0] : '0;
    else                add_r = COMP_mux_1     ? initial_range - u[RANGE_WIDTH-1:0]      : '0;

    sum       = SUM_WIDTH'(low_q) + SUM_WIDTH'(add_r);
    d_s       = cnt_t'(in_d);
    s_sym     = cnt_q + d_s;
    c_hi      = cnt_q + CNT_16;
    sum_m1    = sum & ((SUM_ONE << c_hi) - SUM_ONE);
    c_lo      = c_hi - CNT_8;
    sum_m2    = sum_m1 & ((SUM_ONE << c_lo) - SUM_ONE);
    two_bytes = (s_sym >= CNT_8);
    c_fin     = two_bytes ? c_lo : c_hi;
    sum_fin   = two_bytes ? sum_m2 : sum_m1;

    // Round low up to the 14-bit boundary and force bit 14 for the tail.
    e_init = ((SUM_WIDTH'(low_q) + FLUSH_MASK) & ~FLUSH_MASK) | FLUSH_BIT;
    fsh    = fc_q + CNT_16;
    fmask  = (SUM_ONE << fsh) - SUM_ONE;

    unique case (state_q)
      S_RUN: begin
        if (in_valid) begin
`ifdef STAGE_3_SYMBOL_COUNTER_EN
          count_d = count_q + 32'd1;
`endif
          if (s_sym < CNT_0) begin
            low_d = LOW_WIDTH'(sum << in_d);
            cnt_d = s_sym;
          end else begin
            out_bit_1_d = 9'(sum >> c_hi);
            if (two_bytes) begin
              out_bit_2_d = 9'(sum_m1 >> c_lo);
              out_flag_d  = 2'd2;
            end else begin
              out_flag_d  = 2'd1;
            end
            low_d = LOW_WIDTH'(sum_fin << in_d);
            cnt_d = c_fin + d_s - CNT_24;
          end
        end else if (flush) begin
          state_d = S_FLUSH;
          e_d     = e_init;
          fc_d    = cnt_q;
          fs_d    = cnt_q + CNT_10;
        end
      end
      S_FLUSH: begin
        if (fs_q > CNT_0) begin
          out_bit_1_d = 9'(e_q >> fsh);
          out_flag_d  = 2'd1;
          e_d         = e_q & fmask;
          fc_d        = fc_q - CNT_8;
          fs_d        = fs_q - CNT_8;
        end else begin
          state_d = S_DONE;
          eos_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_RUN;
        low_d   = '0;
        cnt_d   = CNT_INIT;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
        count_d = 32'd0;
`endif
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      low_q       <= '0;
      cnt_q       <= CNT_INIT;
      e_q         <= '0;
      fc_q        <= '0;
      fs_q        <= '0;
      out_flag_q  <= 2'd0;
      out_bit_1_q <= 9'd0;
      out_bit_2_q <= 9'd0;
      eos_q       <= 1'b0;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
      count_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      low_q       <= low_d;
      cnt_q       <= cnt_d;
      e_q         <= e_d;
      fc_q        <= fc_d;
      fs_q        <= fs_d;
      out_flag_q  <= out_flag_d;
      out_bit_1_q <= out_bit_1_d;
      out_bit_2_q <= out_bit_2_d;
      eos_q       <= eos_d;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
      count_q     <= count_d;
`endif
    end
  end

  assign out_flag      = out_flag_q;
  assign out_bit_1     = out_bit_1_q;
  assign out_bit_2     = out_bit_2_q;
  assign end_of_stream = eos_q;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
  assign symbol_count  = count_q;
`endif

endmodule

// File: tb/tb_stage_3_low_update.sv
// -----------------------------------------------------------------------------
// tb_stage_3_low_update
//
// Directed bench for stage_3_low_update. Each scenario task drives its own
// stimulus and compares outputs (and the internal low / cnt registers) against
// hand-computed values. Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_stage_3_low_update;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] u;
  logic [16:0] v_bool;
  logic [15:0] initial_range;
  logic [4:0]  in_d;
  logic [1:0]  bool_symbol;
  logic        comp_mux_1;
  logic        flush;
  logic [1:0]  out_flag;
  logic [8:0]  out_bit_1;
  logic [8:0]  out_bit_2;
  logic        end_of_stream;
`ifdef STAGE_3_SYMBOL_COUNTER_EN
  logic [31:0] symbol_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] CNT_M9 = 7'h77;  // -9
  localparam logic [6:0] CNT_M8 = 7'h78;  // -8
  localparam logic [6:0] CNT_M7 = 7'h79;  // -7
  localparam logic [6:0] CNT_M1 = 7'h7F;  // -1

  stage_3_low_update dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .u             (u),
    .v_bool        (v_bool),
    .initial_range (initial_range),
    .in_d          (in_d),
    .bool_symbol   (bool_symbol),
    .COMP_mux_1    (comp_mux_1),
    .flush         (flush),
    .out_flag      (out_flag),
    .out_bit_1     (out_bit_1),
    .out_bit_2     (out_bit_2),
`ifdef STAGE_3_SYMBOL_COUNTER_EN
    .symbol_count  (symbol_count),
`endif
    .end_of_stream (end_of_stream)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    flush         = 1'b0;
    u             = '0;
    v_bool        = '0;
    initial_range = '0;
    in_d          = '0;
    bool_symbol   = '0;
    comp_mux_1    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_sym(input logic [15:0] rng, input logic [16:0] uu,
                           input logic [16:0] vv, input logic [4:0] d,
                           input logic [1:0] bs, input logic cm);
    in_valid      = 1'b1;
    initial_range = rng;
    u             = uu;
    v_bool        = vv;
    in_d          = d;
    bool_symbol   = bs;
    comp_mux_1    = cm;
  endtask

  // Requests a flush and collects the bytes until end_of_stream or a 20-cycle
  // budget. With junk set, a valid symbol is held on the inputs throughout.
  task automatic run_flush(input bit junk, output int nbytes,
                           output logic [8:0] b0, output logic [8:0] b1,
                           output int bad_flag, output int ready_hi, output bit done);
    nbytes = 0; b0 = '0; b1 = '0; bad_flag = 0; ready_hi = 0; done = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b1;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      tick();
      flush = 1'b0;
      if (junk) drive_sym(16'hFFFF, 17'h00001, 17'h00001, 5'd3, 2'b11, 1'b1);
      if (in_ready !== 1'b0) ready_hi++;
      if (out_flag !== 2'd0) begin
        if (out_flag !== 2'd1) bad_flag++;
        if (nbytes == 0) b0 = out_bit_1;
        else if (nbytes == 1) b1 = out_bit_1;
        nbytes++;
      end
      if (end_of_stream === 1'b1) done = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (out_flag !== 2'd0) begin n_bad++; $display("FAIL reset_out_flag: got %0d want 0", out_flag); end
    n_cmp++; if (out_bit_1 !== 9'd0 || out_bit_2 !== 9'd0) begin n_bad++; $display("FAIL reset_out_bits: got %h/%h want 000/000", out_bit_1, out_bit_2); end
    n_cmp++; if (in_ready !== 1'b1 || end_of_stream !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: in_ready=%b eos=%b want 1/0", in_ready, end_of_stream); end
    n_cmp++; if (dut.low_q !== 24'h0 || dut.cnt_q !== CNT_M9) begin n_bad++; $display("FAIL reset_state: low=%h cnt=%0d want 000000/-9", dut.low_q, $signed(dut.cnt_q)); end
  endtask

  task automatic test_nonbool();
    do_reset();
    drive_sym(16'h8000, 17'h06000, 17'h0, 5'd1, 2'b00, 1'b1);
    tick();
    idle_inputs();
    n_cmp++; if (out_flag !== 2'd0) begin n_bad++; $display("FAIL nonbool_flag: got %0d want 0", out_flag); end
    n_cmp++; if (dut.low_q !== 24'h004000 || dut.cnt_q !== CNT_M8) begin n_bad++; $display("FAIL nonbool_state: low=%h cnt=%0d want 004000/-8", dut.low_q, $signed(dut.cnt_q)); end
  endtask

  task automatic test_bool();
    do_reset();
    drive_sym(16'h8000, 17'h0, 17'h04004, 5'd1, 2'b11, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (out_flag !== 2'd0) begin n_bad++; $display("FAIL bool_flag: got %0d want 0", out_flag); end
    n_cmp++; if (dut.low_q !== 24'h007FF8 || dut.cnt_q !== CNT_M8) begin n_bad++; $display("FAIL bool_state: low=%h cnt=%0d want 007FF8/-8", dut.low_q, $signed(dut.cnt_q)); end
  endtask

  task automatic test_zero_addend();
    do_reset();
    // Bool symbol with bit 0: no addend even though v_bool is far from range.
    drive_sym(16'h8000, 17'h01000, 17'h00010, 5'd1, 2'b10, 1'b1);
    tick();
    n_cmp++; if (dut.low_q !== 24'h0 || dut.cnt_q !== CNT_M8) begin n_bad++; $display("FAIL zero_bool: low=%h cnt=%0d want 000000/-8", dut.low_q, $signed(dut.cnt_q)); end
    // Top-of-CDF symbol: COMP_mux_1 = 0 leaves low untouched.
    drive_sym(16'h8000, 17'h01000, 17'h00010, 5'd1, 2'b00, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (dut.low_q !== 24'h0 || dut.cnt_q !== CNT_M7) begin n_bad++; $display("FAIL zero_comp: low=%h cnt=%0d want 000000/-7", dut.low_q, $signed(dut.cnt_q)); end
  endtask

  task automatic test_single_byte();
    do_reset();
    // add = 0xFFFF - 0x5432 = 0xABCD, cnt = -9, d = 9 -> s = 0.
    drive_sym(16'hFFFF, 17'h05432, 17'h0, 5'd9, 2'b00, 1'b1);
    tick();
    idle_inputs();
    n_cmp++; if (out_flag !== 2'd1) begin n_bad++; $display("FAIL single_flag: got %0d want 1", out_flag); end
    n_cmp++; if (out_bit_1 !== 9'h157 || out_bit_2 !== 9'h000) begin n_bad++; $display("FAIL single_bytes: got %h/%h want 157/000", out_bit_1, out_bit_2); end
    n_cmp++; if (dut.low_q !== 24'h009A00 || dut.cnt_q !== CNT_M8) begin n_bad++; $display("FAIL single_state: low=%h cnt=%0d want 009A00/-8", dut.low_q, $signed(dut.cnt_q)); end
    tick();
    n_cmp++; if (out_flag !== 2'd0 || out_bit_1 !== 9'h000) begin n_bad++; $display("FAIL single_idle: flag=%0d byte=%h want 0/000", out_flag, out_bit_1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // add = 0x1234, d = 8 -> s = -1, low = 0x123400.
    drive_sym(16'h9234, 17'h08000, 17'h0, 5'd8, 2'b00, 1'b1);
    tick();
    n_cmp++; if (out_flag !== 2'd0 || dut.low_q !== 24'h123400 || dut.cnt_q !== CNT_M1) begin n_bad++; $display("FAIL b2b_first: flag=%0d low=%h cnt=%0d want 0/123400/-1", out_flag, dut.low_q, $signed(dut.cnt_q)); end
    // add = 0x56 -> sum = 0x123456, d = 9 -> s = 8, two bytes.
    drive_sym(16'h8056, 17'h08000, 17'h0, 5'd9, 2'b00, 1'b1);
    tick();
    idle_inputs();
    n_cmp++; if (out_flag !== 2'd2) begin n_bad++; $display("FAIL b2b_flag: got %0d want 2", out_flag); end
    n_cmp++; if (out_bit_1 !== 9'h024 || out_bit_2 !== 9'h068) begin n_bad++; $display("FAIL b2b_bytes: got %h/%h want 024/068", out_bit_1, out_bit_2); end
    n_cmp++; if (dut.low_q !== 24'h00AC00 || dut.cnt_q !== CNT_M8) begin n_bad++; $display("FAIL b2b_state: low=%h cnt=%0d want 00AC00/-8", dut.low_q, $signed(dut.cnt_q)); end
`ifdef STAGE_3_SYMBOL_COUNTER_EN
    n_cmp++; if (symbol_count !== 32'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", symbol_count); end
`endif
  endtask

  task automatic check_after_flush(input string tag);
    tick();
    n_cmp++; if (end_of_stream !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_after: eos=%b in_ready=%b want 0/1", tag, end_of_stream, in_ready); end
    n_cmp++; if (dut.low_q !== 24'h0 || dut.cnt_q !== CNT_M9) begin n_bad++; $display("FAIL %s_cleared: low=%h cnt=%0d want 000000/-9", tag, dut.low_q, $signed(dut.cnt_q)); end
  endtask

  task automatic test_flush_reset_state();
    int nb, bf, rh; logic [8:0] b0, b1; bit done;
    do_reset();
    run_flush(1'b0, nb, b0, b1, bf, rh, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL flush0_eos: end_of_stream not seen within 20 cycles"); end
    n_cmp++; if (nb != 1 || b0 !== 9'h080 || bf != 0) begin n_bad++; $display("FAIL flush0_bytes: n=%0d b0=%h badflag=%0d want 1/080/0", nb, b0, bf); end
    n_cmp++; if (rh != 0) begin n_bad++; $display("FAIL flush0_ready: in_ready high on %0d cycles want 0", rh); end
    check_after_flush("flush0");
  endtask

  task automatic test_flush_two_bytes();
    int nb, bf, rh; logic [8:0] b0, b1; bit done;
    do_reset();
    drive_sym(16'h9234, 17'h08000, 17'h0, 5'd8, 2'b00, 1'b1);
    tick();
    // low = 0x123400, cnt = -1 -> e = 0x124000, s = 9: bytes 0x024 then 0x080.
    // A symbol held on the inputs during the flush must be ignored.
    run_flush(1'b1, nb, b0, b1, bf, rh, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL flush2_eos: end_of_stream not seen within 20 cycles"); end
    n_cmp++; if (nb != 2 || b0 !== 9'h024 || b1 !== 9'h080 || bf != 0) begin n_bad++; $display("FAIL flush2_bytes: n=%0d b=%h,%h badflag=%0d want 2/024,080/0", nb, b0, b1, bf); end
    n_cmp++; if (rh != 0) begin n_bad++; $display("FAIL flush2_ready: in_ready high on %0d cycles want 0", rh); end
    check_after_flush("flush2");
  endtask

  task automatic test_flush_with_valid();
    int nb, bf, rh; logic [8:0] b0, b1; bit done;
    do_reset();
    drive_sym(16'h8000, 17'h06000, 17'h0, 5'd1, 2'b00, 1'b1);
    flush = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || dut.low_q !== 24'h004000) begin n_bad++; $display("FAIL fv_symbol_first: in_ready=%b low=%h want 1/004000", in_ready, dut.low_q); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fv_flush_next: in_ready=%b want 0", in_ready); end
    // low = 0x4000, cnt = -8 -> e = 0x4000, s = 2: one byte 0x040.
    run_flush(1'b0, nb, b0, b1, bf, rh, done);
    n_cmp++; if (done !== 1'b1 || nb != 1 || b0 !== 9'h040 || bf != 0) begin n_bad++; $display("FAIL fv_bytes: done=%b n=%0d b0=%h want 1/1/040", done, nb, b0); end
    check_after_flush("fv");
  endtask

  task automatic test_reset_mid_flush();
    int eos_seen = 0;
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmf_in_flush: in_ready=%b want 0", in_ready); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_flag !== 2'd0 || out_bit_1 !== 9'd0) begin n_bad++; $display("FAIL rmf_async: in_ready=%b flag=%0d byte=%h want 1/0/000", in_ready, out_flag, out_bit_1); end
    repeat (2) begin
      tick();
      if (end_of_stream !== 1'b0 || out_flag !== 2'd0) eos_seen++;
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      if (end_of_stream !== 1'b0 || out_flag !== 2'd0) eos_seen++;
    end
    n_cmp++; if (eos_seen != 0) begin n_bad++; $display("FAIL rmf_no_output: %0d cycles with eos/bytes want 0", eos_seen); end
    n_cmp++; if (in_ready !== 1'b1 || dut.low_q !== 24'h0 || dut.cnt_q !== CNT_M9) begin n_bad++; $display("FAIL rmf_state: in_ready=%b low=%h cnt=%0d want 1/000000/-9", in_ready, dut.low_q, $signed(dut.cnt_q)); end
  endtask

  initial begin
    test_reset();
    test_nonbool();
    test_bool();
    test_zero_addend();
    test_single_byte();
    test_back_to_back();
    test_flush_reset_state();
    test_flush_two_bytes();
    test_flush_with_valid();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
